// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: aluc codes, MIPS opcode and
// funct encodings, branch-type encoding and the registered issue record.
package alu_pkg;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEQ  = 2'b01,
        BR_BNE  = 2'b10
    } branch_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  aluc;
        logic        wreg;
        logic [4:0]  dest;
        logic        m2reg;
        logic        wmem;
        logic [1:0]  branch;
        logic        illegal;
    } issue_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of one MIPS instruction into ALU issue fields.
// Optional variable shifts (sllv/srlv/srav) are enabled by ALU_ISSUE_SHIFTV_EN.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [31:0] inst,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  aluc,
    output logic        wreg,
    output logic [4:0]  dest,
    output logic        m2reg,
    output logic        wmem,
    output logic [1:0]  branch,
    output logic        illegal
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] imm_sx;
    logic [31:0] imm_zx;
    logic        unused_rs_field;

    assign op     = inst[31:26];
    assign funct  = inst[5:0];
    assign imm_sx = {{16{inst[15]}}, inst[15:0]};
    assign imm_zx = {16'h0000, inst[15:0]};
    // rs arrives already read from the register file; the field itself is not needed
    assign unused_rs_field = ^inst[25:21];

    // Decode op/funct into operands and controls; undecodable words collapse to all-zero fields
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        aluc    = ALUC_ADD;
        wreg    = 1'b0;
        dest    = '0;
        m2reg   = 1'b0;
        wmem    = 1'b0;
        branch  = BR_NONE;
        illegal = 1'b0;
        case (op)
            OP_RTYPE: begin
                alu_a = rs_data;
                alu_b = rt_data;
                wreg  = 1'b1;
                dest  = inst[15:11];
                case (funct)
                    FN_ADD: aluc = ALUC_ADD;
                    FN_SUB: aluc = ALUC_SUB;
                    FN_AND: aluc = ALUC_AND;
                    FN_OR:  aluc = ALUC_OR;
                    FN_XOR: aluc = ALUC_XOR;
                    FN_SLL: begin aluc = ALUC_SLL; alu_a = {27'b0, inst[10:6]}; end
                    FN_SRL: begin aluc = ALUC_SRL; alu_a = {27'b0, inst[10:6]}; end
                    FN_SRA: begin aluc = ALUC_SRA; alu_a = {27'b0, inst[10:6]}; end
`ifdef ALU_ISSUE_SHIFTV_EN
                    FN_SLLV: begin aluc = ALUC_SLL; alu_a = {27'b0, rs_data[4:0]}; end
                    FN_SRLV: begin aluc = ALUC_SRL; alu_a = {27'b0, rs_data[4:0]}; end
                    FN_SRAV: begin aluc = ALUC_SRA; alu_a = {27'b0, rs_data[4:0]}; end
`endif
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: begin
                alu_a = rs_data;
                alu_b = imm_sx;
                dest  = inst[20:16];
                wreg  = (op != OP_SW);
                m2reg = (op == OP_LW);
                wmem  = (op == OP_SW);
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                alu_a = rs_data;
                alu_b = imm_zx;
                dest  = inst[20:16];
                wreg  = 1'b1;
                aluc  = (op == OP_ANDI) ? ALUC_AND : (op == OP_ORI) ? ALUC_OR : ALUC_XOR;
            end
            OP_LUI: begin
                alu_b = imm_zx;
                dest  = inst[20:16];
                wreg  = 1'b1;
                aluc  = ALUC_LUI;
            end
            OP_BEQ, OP_BNE: begin
                alu_a  = rs_data;
                alu_b  = rt_data;
                dest   = inst[20:16];
                aluc   = ALUC_SUB;
                branch = (op == OP_BEQ) ? BR_BEQ : BR_BNE;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            alu_a  = '0;
            alu_b  = '0;
            aluc   = ALUC_ADD;
            wreg   = 1'b0;
            dest   = '0;
            m2reg  = 1'b0;
            wmem   = 1'b0;
            branch = BR_NONE;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered decode-and-issue stage with valid/ready handshake in front of the ALU.
// Optional variable-shift decode: define ALU_ISSUE_SHIFTV_EN.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inst,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  aluc,
    output logic        wreg,
    output logic [4:0]  dest,
    output logic        m2reg,
    output logic        wmem,
    output logic [1:0]  branch,
    output logic        illegal
);

    issue_t dec;
    issue_t issue_q, issue_d;
    logic   valid_q, valid_d;
    logic   accept;

    alu_op_decode u_decode (
        .inst    (inst),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .alu_a   (dec.a),
        .alu_b   (dec.b),
        .aluc    (dec.aluc),
        .wreg    (dec.wreg),
        .dest    (dec.dest),
        .m2reg   (dec.m2reg),
        .wmem    (dec.wmem),
        .branch  (dec.branch),
        .illegal (dec.illegal)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Next entry: flush beats accept, accept beats drain, otherwise hold
    always_comb begin
        valid_d = valid_q;
        issue_d = issue_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            issue_d = dec;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            issue_q <= '0;
        end else begin
            valid_q <= valid_d;
            issue_q <= issue_d;
        end
    end

    assign out_valid = valid_q;
    assign alu_a     = issue_q.a;
    assign alu_b     = issue_q.b;
    assign aluc      = issue_q.aluc;
    assign wreg      = issue_q.wreg;
    assign dest      = issue_q.dest;
    assign m2reg     = issue_q.m2reg;
    assign wmem      = issue_q.wmem;
    assign branch    = issue_q.branch;
    assign illegal   = issue_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed cases plus randomized
// traffic compared against an instruction-level reference model.
module tb_alu_issue_stage;

    logic        clock = 1'b0;
    logic        resetn, in_valid, flush, out_ready;
    logic [31:0] inst, rs_data, rt_data;
    logic        in_ready, out_valid, wreg, m2reg, wmem, illegal;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  aluc;
    logic [4:0]  dest;
    logic [1:0]  branch;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  aluc;
        logic        wreg;
        logic [4:0]  dest;
        logic        m2reg;
        logic        wmem;
        logic [1:0]  br;
        logic        ill;
    } exp_t;

    exp_t m_iss;
    logic m_valid;
    logic m_zeroed;

    alu_issue_stage dut (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
        .aluc(aluc), .wreg(wreg), .dest(dest), .m2reg(m2reg), .wmem(wmem),
        .branch(branch), .illegal(illegal)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Instruction-level meaning of each supported MIPS instruction
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] rs, input logic [31:0] rt);
        exp_t e;
        logic ok;
        logic [31:0] sx, zx;
        sx = {{16{w[15]}}, w[15:0]};
        zx = {16'h0000, w[15:0]};
        e  = '0;
        ok = 1'b1;
        case (w[31:26])
            6'h00: begin
                e.wreg = 1'b1; e.dest = w[15:11]; e.a = rs; e.b = rt;
                case (w[5:0])
                    6'h20: e.aluc = 4'b0000;
                    6'h22: e.aluc = 4'b0100;
                    6'h24: e.aluc = 4'b0001;
                    6'h25: e.aluc = 4'b0101;
                    6'h26: e.aluc = 4'b0010;
                    6'h00: begin e.aluc = 4'b0011; e.a = 32'(w[10:6]); end
                    6'h02: begin e.aluc = 4'b0111; e.a = 32'(w[10:6]); end
                    6'h03: begin e.aluc = 4'b1111; e.a = 32'(w[10:6]); end
`ifdef ALU_ISSUE_SHIFTV_EN
                    6'h04: begin e.aluc = 4'b0011; e.a = rs % 32; end
                    6'h06: begin e.aluc = 4'b0111; e.a = rs % 32; end
                    6'h07: begin e.aluc = 4'b1111; e.a = rs % 32; end
`endif
                    default: ok = 1'b0;
                endcase
            end
            6'h08: begin e.a = rs; e.b = sx; e.wreg = 1'b1; e.dest = w[20:16]; end
            6'h23: begin e.a = rs; e.b = sx; e.wreg = 1'b1; e.m2reg = 1'b1; e.dest = w[20:16]; end
            6'h2B: begin e.a = rs; e.b = sx; e.wmem = 1'b1; e.dest = w[20:16]; end
            6'h0C: begin e.a = rs; e.b = zx; e.aluc = 4'b0001; e.wreg = 1'b1; e.dest = w[20:16]; end
            6'h0D: begin e.a = rs; e.b = zx; e.aluc = 4'b0101; e.wreg = 1'b1; e.dest = w[20:16]; end
            6'h0E: begin e.a = rs; e.b = zx; e.aluc = 4'b0010; e.wreg = 1'b1; e.dest = w[20:16]; end
            6'h0F: begin e.b = zx; e.aluc = 4'b0110; e.wreg = 1'b1; e.dest = w[20:16]; end
            6'h04: begin e.a = rs; e.b = rt; e.aluc = 4'b0100; e.br = 2'b01; e.dest = w[20:16]; end
            6'h05: begin e.a = rs; e.b = rt; e.aluc = 4'b0100; e.br = 2'b10; e.dest = w[20:16]; end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e = '0;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] rs,
                         input logic [31:0] rt, input logic ordy, input logic fl);
        in_valid = v; inst = w; rs_data = rs; rt_data = rt; out_ready = ordy; flush = fl;
    endtask

    // One clock: check in_ready, advance the model with pre-edge inputs, then check outputs
    task automatic cycle();
        #1;
        chk("in_ready", in_ready, !m_valid || out_ready);
        if (!resetn) begin
            m_valid = 1'b0; m_iss = '0; m_zeroed = 1'b1;
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_valid = 1'b1; m_iss = ref_decode(inst, rs_data, rt_data); m_zeroed = 1'b0;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clock);
        #1;
        chk("out_valid", out_valid, m_valid);
        if (m_valid || m_zeroed) begin
            chk("alu_a", alu_a, m_iss.a);
            chk("alu_b", alu_b, m_iss.b);
            chk("aluc", aluc, m_iss.aluc);
            chk("wreg", wreg, m_iss.wreg);
            chk("dest", dest, m_iss.dest);
            chk("m2reg", m2reg, m_iss.m2reg);
            chk("wmem", wmem, m_iss.wmem);
            chk("branch", branch, m_iss.br);
            chk("illegal", illegal, m_iss.ill);
        end
    endtask

    logic [5:0] ops [12] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h0C,
                             6'h0D, 6'h0E, 6'h0F, 6'h04, 6'h05};
    logic [5:0] fns [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02,
                             6'h03, 6'h04, 6'h06, 6'h07, 6'h01};

    initial begin
        logic [31:0] w;
        logic [31:0] hold_a;
        m_valid = 1'b0; m_iss = '0; m_zeroed = 1'b0;
        resetn = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(posedge clock);
        cycle();
        cycle();
        chk("rst_out_valid", out_valid, 1'b0);
        resetn = 1'b1;

        // addi $2,$1,-1
        drive(1'b1, 32'h2022FFFF, 32'd5, 32'd0, 1'b1, 1'b0);
        cycle();
        chk("addi_b", alu_b, 32'hFFFFFFFF);
        chk("addi_a", alu_a, 32'd5);
        chk("addi_dest", dest, 5'd2);

        // sll $3,$4,4
        drive(1'b1, 32'h00041900, 32'h0, 32'h1, 1'b1, 1'b0);
        cycle();
        chk("sll_aluc", aluc, 4'b0011);
        chk("sll_a", alu_a, 32'd4);

        // lui $5,0x1234
        drive(1'b1, 32'h3C051234, 32'h77, 32'h0, 1'b1, 1'b0);
        cycle();
        chk("lui_b", alu_b, 32'h00001234);
        chk("lui_a", alu_a, 32'h0);

        // beq then sw back to back
        drive(1'b1, 32'h10220003, 32'h11, 32'h22, 1'b1, 1'b0);
        cycle();
        chk("beq_branch", branch, 2'b01);
        drive(1'b1, 32'hAC220008, 32'h100, 32'h5, 1'b1, 1'b0);
        cycle();
        chk("sw_wmem", wmem, 1'b1);
        chk("sw_valid", out_valid, 1'b1);

        // stall three cycles with a pending input
        hold_a = alu_a;
        drive(1'b1, 32'h2001000A, 32'h3, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_a", alu_a, hold_a);
        end

        // variable shift sllv $3,$2,$1
        drive(1'b1, 32'h00221804, 32'h25, 32'h2, 1'b1, 1'b0);
        cycle();
        cycle();
`ifdef ALU_ISSUE_SHIFTV_EN
        chk("sllv_aluc", aluc, 4'b0011);
        chk("sllv_a", alu_a, 32'd5);
`else
        chk("sllv_ill", illegal, 1'b1);
        chk("sllv_wreg", wreg, 1'b0);
`endif

        // flush with a new input while an entry is held
        drive(1'b1, 32'h20030001, 32'h1, 32'h0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'h20040002, 32'h1, 32'h0, 1'b0, 1'b1);
        cycle();
        chk("flush_valid", out_valid, 1'b0);

        // reset during a stall
        drive(1'b1, 32'h20050003, 32'h9, 32'h0, 1'b0, 1'b0);
        cycle();
        resetn = 1'b0;
        cycle();
        chk("rst_stall_valid", out_valid, 1'b0);
        chk("rst_stall_a", alu_a, 32'h0);
        resetn = 1'b1;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            w = $urandom;
            if ($urandom_range(0, 9) != 0) begin
                int k;
                k = $urandom_range(0, 11);
                w[31:26] = ops[k];
                if (ops[k] == 6'h00) w[5:0] = fns[$urandom_range(0, 11)];
            end
            resetn = ($urandom_range(0, 199) != 0);
            drive($urandom_range(0, 3) != 0, w, $urandom, $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Registered decode-and-issue stage in front of the single-cycle ALU. Accepts one 32-bit MIPS instruction plus its register-file read data per handshake. Encodes it into the ALU's `aluc` operation code and operands `a`/`b`, plus writeback, memory and branch controls. Holds the result in an output register with a valid/ready handshake, so fetch/regfile logic and the execute stage can stall independently.

## Interface
Parameters:
- none; all widths fixed at 32-bit datapath, 5-bit register addresses.

Ports:
- `clock` in 1: sole clock, rising edge.
- `resetn` in 1: reset, synchronous and active-low.
- `in_valid` in 1: instruction and read data present.
- `in_ready` out 1: stage can accept this cycle.
- `inst` in 32: instruction word.
- `rs_data` in 32: GPR[rs].
- `rt_data` in 32: GPR[rt].
- `flush` in 1: discard registered entry and any same-cycle input.
- `out_valid` out 1: issued op valid.
- `out_ready` in 1: execute stage consumes.
- `alu_a` out 32: ALU operand a.
- `alu_b` out 32: ALU operand b.
- `aluc` out 4: ALU operation code.
- `wreg` out 1: result written to GPR.
- `dest` out 5: rd for R-type, rt for I-type.
- `m2reg` out 1: lw.
- `wmem` out 1: sw.
- `branch` out 2: 00 none, 01 beq, 10 bne (consumer uses ALU `z`).
- `illegal` out 1: undecodable instruction.

## Operation
- `aluc` codes:
  - ADD `0000`, SUB `0100`, AND `0001`, OR `0101`, XOR `0010`.
  - LUI `0110`.
  - SLL `0011`, SRL `0111`, SRA `1111`.
- R-type (op `000000`), selected by funct:
  - add `100000`, sub `100010`, and `100100`, or `100101`, xor `100110`: a=rs_data, b=rt_data, wreg=1, dest=rd.
  - sll `000000`, srl `000010`, sra `000011`: a={27'b0,sa}, b=rt_data.
- I-type: dest=rt.
  - addi `001000`, lw `100011`, sw `101011`: ADD, b=sign-extended imm16.
  - andi `001100`, ori `001101`, xori `001110`: b=zero-extended imm16.
  - lui `001111`: LUI, b=zero-extended imm16, a=0.
  - beq `000100`, bne `000101`: SUB, a=rs_data, b=rt_data, wreg=0.
  - lw sets m2reg=1, wreg=1. sw sets wmem=1, wreg=0.
- Any other op/funct: illegal=1, aluc=`0000`, a=b=0, wreg=m2reg=wmem=0, branch=00. Still issued with out_valid=1.
- Output register updates only on accept (`in_valid && in_ready && !flush`). Otherwise it holds.

## Timing
- Reset (resetn=0 at edge): out_valid=0 and all data outputs 0. Any in-flight entry is dropped.
- `in_ready = !out_valid || out_ready`, combinational. No path from `in_valid` to `in_ready`.
- Latency: accepted at edge N, visible on outputs after edge N. Throughput 1/cycle while out_ready=1.
- Stall: out_valid=1 and out_ready=0 → all outputs stable, in_ready=0.
- Simultaneous drain and accept (out_valid=1, out_ready=1, in_valid=1) → new entry replaces old at the same edge, out_valid stays 1.
- Drain without input → out_valid=0 next cycle.
- Flush has priority over accept and hold: out_valid=0 next cycle, input dropped. in_ready is not gated by flush.
- Reset has priority over flush.

## Configuration
- `ALU_ISSUE_SHIFTV_EN` defined: decode sllv `000100`, srlv `000110`, srav `000111` as SLL/SRL/SRA with a={27'b0,rs_data[4:0]}, b=rt_data, wreg=1, dest=rd.
- Undefined: those funct codes decode as illegal.

## Structure
- Shared package `alu_pkg`: aluc constants, opcode and funct constants, branch-type encoding.
- Sub-module `alu_op_decode`: purely combinational inst/rs_data/rt_data → issue fields, including the macro-dependent shifts. `alu_issue_stage` wraps it with the handshake register.

## Test plan
- Reset then `addi $2,$1,-1` (inst `0x2022FFFF`, rs_data=5) → next cycle out_valid=1, aluc=`0000`, a=5, b=`0xFFFFFFFF`, dest=2, wreg=1.
- `sll $3,$4,4` (inst `0x00041900`, rt_data=`0x1`) → aluc=`0011`, a=4, b=1, dest=3. `lui` with imm `0x1234` → aluc=`0110`, b=`0x00001234`.
- Back-to-back beq then sw with out_ready=1 → two consecutive valid cycles: first SUB/branch=01/wreg=0, then ADD/wmem=1. Hold out_ready=0 for 3 cycles → outputs frozen, in_ready=0.
- inst `0x00221804` (sllv): with macro → aluc=`0011`, a=rs_data[4:0]. Without macro → illegal=1, aluc=`0000`, wreg=0.
- Flush asserted with in_valid=1 while out_valid=1 → out_valid=0 next cycle, input not issued. resetn=0 during a stall → out_valid=0, outputs 0 after that edge.
